// File: rtl/pit_data_rx.sv
// PIT-side responder for returning Data: PIT lookup handshake, accept/reject answer to the FIB,
// then forwards the DATA_BYTES payload tagged with the requesting face and clears the PIT entry.
module pit_data_rx #(
    parameter int DATA_BYTES  = 1024,
    parameter int CNT_W       = 10,
    parameter int FACE_W      = 2,
    parameter int LKP_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fib_prefix_ready,
    input  logic [63:0]       fib_prefix,
    input  logic [5:0]        fib_len,
    input  logic [7:0]        fib_data,
    output logic              rejected,
    output logic              start_send_to_pit,
    output logic              lkp_req,
    output logic [63:0]       lkp_prefix,
    output logic [5:0]        lkp_len,
    input  logic              lkp_done,
    input  logic              lkp_hit,
    input  logic [FACE_W-1:0] lkp_face,
    output logic              rx_valid,
    output logic [7:0]        rx_data,
    output logic [FACE_W-1:0] rx_face,
    output logic              rx_first,
    output logic              rx_last,
    output logic              entry_clear,
    output logic              busy
);
    localparam int TMO_W = $clog2(LKP_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(DATA_BYTES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(LKP_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, WAIT_LKP, REJECT, ACCEPT, RECEIVE} state_t;

    state_t           state;
    logic [TMO_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] byte_cnt;

    // Pulse outputs are set on the edge that enters their state, so they coincide with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            tmo_cnt           <= '0;
            byte_cnt          <= '0;
            rejected          <= 1'b0;
            start_send_to_pit <= 1'b0;
            lkp_req           <= 1'b0;
            lkp_prefix        <= '0;
            lkp_len           <= '0;
            rx_valid          <= 1'b0;
            rx_data           <= '0;
            rx_face           <= '0;
            rx_first          <= 1'b0;
            rx_last           <= 1'b0;
            entry_clear       <= 1'b0;
            busy              <= 1'b0;
        end else begin
            rejected          <= 1'b0;
            start_send_to_pit <= 1'b0;
            lkp_req           <= 1'b0;
            rx_valid          <= 1'b0;
            rx_first          <= 1'b0;
            rx_last           <= 1'b0;
            entry_clear       <= 1'b0;
            case (state)
                IDLE: begin
                    if (fib_prefix_ready) begin
                        lkp_prefix <= fib_prefix;
                        lkp_len    <= fib_len;
                        busy       <= 1'b1;
                        if (fib_len != '0) begin
                            state   <= LOOKUP;
                            lkp_req <= 1'b1;
                        end else begin
                            state    <= REJECT;
                            rejected <= 1'b1;
                        end
                    end
                end
                LOOKUP: begin
                    state   <= WAIT_LKP;
                    tmo_cnt <= '0;
                end
                WAIT_LKP: begin
                    // A response on the final allowed cycle is honoured before the timeout.
                    if (lkp_done && lkp_hit) begin
                        rx_face           <= lkp_face;
                        state             <= ACCEPT;
                        start_send_to_pit <= 1'b1;
                    end else if (lkp_done || tmo_cnt == TMO_LAST) begin
                        state    <= REJECT;
                        rejected <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                REJECT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                ACCEPT: begin
                    state    <= RECEIVE;
                    byte_cnt <= '0;
                end
                RECEIVE: begin
                    rx_valid <= 1'b1;
                    rx_data  <= fib_data;
                    rx_first <= (byte_cnt == '0);
                    byte_cnt <= byte_cnt + 1'b1;
                    if (byte_cnt == LAST_BYTE) begin
                        rx_last     <= 1'b1;
                        entry_clear <= 1'b1;
                        state       <= IDLE;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pit_data_rx.sv
// Directed + randomized bench for pit_data_rx; each transaction's expected timeline is derived
// from the handshake rules (cycle offsets from the strobe) and checked every cycle.
module tb_pit_data_rx;
    localparam int N   = 1024;
    localparam int TMO = 15;
    localparam int FW  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fib_prefix_ready = 1'b0;
    logic [63:0]   fib_prefix = '0;
    logic [5:0]    fib_len = '0;
    logic [7:0]    fib_data = '0;
    logic          rejected, start_send_to_pit, lkp_req;
    logic [63:0]   lkp_prefix;
    logic [5:0]    lkp_len;
    logic          lkp_done = 1'b0;
    logic          lkp_hit = 1'b0;
    logic [FW-1:0] lkp_face = '0;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic [FW-1:0] rx_face;
    logic          rx_first, rx_last, entry_clear, busy;

    int ncmp  = 0;
    int nfail = 0;
    logic [7:0] pay [N];

    pit_data_rx #(.DATA_BYTES(N), .CNT_W(10), .FACE_W(FW), .LKP_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .fib_prefix_ready(fib_prefix_ready), .fib_prefix(fib_prefix), .fib_len(fib_len),
        .fib_data(fib_data), .rejected(rejected), .start_send_to_pit(start_send_to_pit),
        .lkp_req(lkp_req), .lkp_prefix(lkp_prefix), .lkp_len(lkp_len),
        .lkp_done(lkp_done), .lkp_hit(lkp_hit), .lkp_face(lkp_face),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_face(rx_face),
        .rx_first(rx_first), .rx_last(rx_last), .entry_clear(entry_clear), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] flags();
        return {lkp_req, rejected, start_send_to_pit, rx_valid, rx_first, rx_last, entry_clear, busy};
    endfunction

    // Strobe is driven in cycle c=0; dly = WAIT cycle index carrying lkp_done; spur = cycle of an
    // extra strobe that must be ignored; abort_k = payload byte at which rst is pulsed (-1: none).
    task automatic txn(input logic [63:0] pfx, input logic [5:0] len, input int dly, input bit hit,
                       input logic [FW-1:0] face, input int spur, input int abort_k);
        int rej_c, acc_c, end_c;
        bit acc;
        logic [7:0] ef;
        for (int k = 0; k < N; k++) pay[k] = 8'($urandom);
        rej_c = -1; acc_c = -1; acc = 1'b0;
        if (len == 6'd0)    rej_c = 1;
        else if (dly < TMO) begin
            if (hit) begin acc = 1'b1; acc_c = 3 + dly; end
            else rej_c = 3 + dly;
        end else            rej_c = 2 + TMO;
        end_c = acc ? acc_c + N + 1 : rej_c + 1;
        fib_prefix = pfx; fib_len = len; fib_prefix_ready = 1'b1;
        for (int c = 1; c <= end_c; c++) begin
            @(negedge clk);
            fib_prefix_ready = 1'b0;
            lkp_done = 1'b0;
            lkp_hit  = 1'($urandom);
            lkp_face = FW'($urandom);
            fib_data = 8'($urandom);
            ef = '0;
            ef[7] = (len != 6'd0 && c == 1);
            ef[6] = (c == rej_c);
            ef[5] = (c == acc_c);
            if (acc && c >= acc_c + 2) begin
                ef[4] = 1'b1;
                ef[3] = (c == acc_c + 2);
                ef[2] = (c == end_c);
                ef[1] = (c == end_c);
            end
            ef[0] = (c < end_c);
            chk("flags{req,rej,start,vld,first,last,clr,busy}", 64'(flags()), 64'(ef));
            if (c == 1) begin
                chk("lkp_prefix", lkp_prefix, pfx);
                chk("lkp_len", 64'(lkp_len), 64'(len));
            end
            if (ef[4]) begin
                chk("rx_data", 64'(rx_data), 64'(pay[c - acc_c - 2]));
                chk("rx_face", 64'(rx_face), 64'(face));
            end
            if (acc && abort_k >= 0 && c == acc_c + 2 + abort_k) begin
                #1 rst = 1'b1;
                #1 chk("abort_outputs", {40'd0, flags(), rx_data, 6'(rx_face), lkp_len},
                       64'd0);
                chk("abort_prefix", lkp_prefix, 64'd0);
                @(negedge clk);
                rst = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("post_abort_flags", 64'(flags()), 64'd0);
                end
                return;
            end
            if (c == end_c && spur != 0) chk("prefix_held", lkp_prefix, pfx);
            if (len != 6'd0 && c == 2 + dly) begin
                lkp_done = 1'b1; lkp_hit = hit; lkp_face = face;
            end
            if (acc && c >= acc_c + 1 && c <= acc_c + N) fib_data = pay[c - acc_c - 1];
            if (c == spur) begin
                fib_prefix_ready = 1'b1; fib_prefix = ~pfx; fib_len = 6'd5;
            end
        end
    endtask

    initial begin
        #2;
        chk("reset_flags", 64'(flags()), 64'd0);
        chk("reset_data", {46'd0, rx_data, 6'(rx_face), 6'd0} | 64'(lkp_len), 64'd0);
        chk("reset_prefix", lkp_prefix, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        // Hit with one-cycle lookup: start_send lands at strobe+3, the 4th cycle counting the strobe.
        txn(64'hA5, 6'd8, 0, 1'b1, 2'd2, 0, -1);
        // Strobe in the rx_last cycle (IDLE again) is taken: miss.
        txn(64'h1234_5678_9ABC_DEF0, 6'd17, 0, 1'b0, 2'd1, 0, -1);
        // Timeout: no done; then done arriving on the REJECT cycle is ignored.
        txn(64'hCAFE, 6'd12, TMO + 3, 1'b1, 2'd3, 0, -1);
        txn(64'hBEEF, 6'd12, TMO, 1'b1, 2'd3, 0, -1);
        // done&hit on the expiry (last WAIT) cycle wins.
        txn(64'hF00D, 6'd40, TMO - 1, 1'b1, 2'd1, 0, -1);
        // Zero-length prefix rejects without a lookup.
        txn(64'hDEAD, 6'd0, 0, 1'b1, 2'd0, 0, -1);
        // Mid-packet reset, then a full packet.
        txn(64'h77, 6'd9, 1, 1'b1, 2'd3, 0, 500);
        txn(64'h88, 6'd9, 2, 1'b1, 2'd2, 0, -1);
        // Strobes while busy (RECEIVE, REJECT) are dropped.
        txn(64'h99, 6'd10, 2, 1'b1, 2'd1, 105, -1);
        txn(64'hAA, 6'd10, 1, 1'b0, 2'd1, 4, -1);
        for (int r = 0; r < 6; r++)
            txn({$urandom, $urandom}, 6'($urandom), int'($urandom_range(0, TMO + 2)),
                1'($urandom), FW'($urandom), 0, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
